interp_block_sequencer: RTL and testbench

Control sequencer for one 8x8 sub-pixel interpolation block. It primes the 15-row input shift register from an upstream row source, then steps the filter output into the 40-word output filler. It presents the finished block downstream with a valid/ready handshake. It sits between the reference-pixel fetch stage and the input_shift_reg / filter / output_filler datapath, and drives their active-low load and reset strobes.

---
 rtl/interp_block_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_interp_block_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_block_sequencer.sv
// -----------------------------------------------------------------------------
// interp_block_sequencer
//
// Control sequencer for one 8x8 sub-pixel interpolation block. It primes the
// input shift register with ROWS_IN rows from the upstream row source, then
// steps WORDS_OUT filter result words into the output filler. It then holds
// the finished block until downstream acknowledges it.
//
// Optional feature macro: INTERP_SEQ_PERF_CNT_EN
//   When defined, two 32-bit saturating performance counters are added:
//   perf_busy_cyc (cycles not in IDLE) and perf_stall_cyc (FILL/EMIT cycles
//   with the relevant valid low). Both are cleared only by reset.
//
// Ports:
//   clock        single clock, all state updates on posedge
//   reset        asynchronous, active-high reset
//   start        begin a block (sampled only in IDLE)
//   busy         high in every state except IDLE
//   row_req      high in FILL (requesting input rows)
//   row_valid    upstream row present this cycle
//   in_load_L    active-low load strobe to the input shift register
//   filt_valid   filter result word valid this cycle
//   out_load_L   active-low load strobe to the output filler
//   sel          index of the current output word (0..WORDS_OUT-1)
//   dp_reset_L   active-low datapath clear (low in reset and in CLEAR)
//   blk_valid    completed block held in the output filler
//   blk_ready    downstream has consumed the block
//   perf_busy_cyc / perf_stall_cyc  (only with INTERP_SEQ_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module interp_block_sequencer #(
  parameter int unsigned ROWS_IN   = 15,
  parameter int unsigned WORDS_OUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        row_req,
  input  logic        row_valid,
  output logic        in_load_L,
  input  logic        filt_valid,
  output logic        out_load_L,
  output logic [7:0]  sel,
  output logic        dp_reset_L,
  output logic        blk_valid,
  input  logic        blk_ready
`ifdef INTERP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_stall_cyc
`endif
);

  localparam logic [3:0] ROW_LAST  = 4'(ROWS_IN - 1);
  localparam logic [7:0] WORD_LAST = 8'(WORDS_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_EMIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] row_cnt_q, row_cnt_d;
  logic [7:0] word_cnt_q, word_cnt_d;

  logic row_acc;
  logic word_acc;

  // A valid only counts in the state that consumes it; a stray strobe in any
  // other state neither loads the datapath nor moves a counter.
  assign row_acc  = (state_q == S_FILL) && row_valid;
  assign word_acc = (state_q == S_EMIT) && filt_valid;

  // ---------------------------------------------------------------------------
  // Next-state and counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    word_cnt_d = word_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          // Clearing on entry as well makes sel read 0 throughout CLEAR.
          row_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end

      S_CLEAR: begin
        row_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = S_FILL;
      end

      S_FILL: begin
        if (row_acc) begin
          if (row_cnt_q == ROW_LAST) begin
            state_d = S_EMIT;
          end else begin
            row_cnt_d = row_cnt_q + 4'd1;
          end
        end
      end

      S_EMIT: begin
        if (word_acc) begin
          // The final word does not advance the counter, so sel parks at
          // WORDS_OUT-1 for the whole of HOLD.
          if (word_cnt_q == WORD_LAST) begin
            state_d = S_HOLD;
          end else begin
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end
      end

      S_HOLD: begin
        // start in the same cycle is deliberately not captured here.
        if (blk_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != S_IDLE);
    row_req    = (state_q == S_FILL);
    blk_valid  = (state_q == S_HOLD);
    in_load_L  = ~row_acc;
    out_load_L = ~word_acc;
    // Reset is folded in combinationally so the datapath is held clear for
    // the full duration of an asynchronous reset.
    dp_reset_L = ~(reset | (state_q == S_CLEAR));
    sel        = word_cnt_q;
  end

`ifdef INTERP_SEQ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] busy_cyc_q, busy_cyc_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic        stall_now;

  assign stall_now = ((state_q == S_FILL) && !row_valid) ||
                     ((state_q == S_EMIT) && !filt_valid);

  always_comb begin
    busy_cyc_d  = busy_cyc_q;
    stall_cyc_d = stall_cyc_q;
    if ((state_q != S_IDLE) && (busy_cyc_q != '1)) begin
      busy_cyc_d = busy_cyc_q + 32'd1;
    end
    if (stall_now && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      busy_cyc_q  <= busy_cyc_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_busy_cyc  = busy_cyc_q;
  assign perf_stall_cyc = stall_cyc_q;
`endif

endmodule

// File: tb/tb_interp_block_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for interp_block_sequencer: a short vector table, directed
// multi-cycle sequences and randomized traffic, all compared every cycle
// against a block-level model (rows received, words received, active flag).
// -----------------------------------------------------------------------------
module tb_interp_block_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, row_valid, filt_valid, blk_ready;
  logic       busy, row_req, in_load_L, out_load_L, dp_reset_L, blk_valid;
  logic [7:0] sel;
`ifdef INTERP_SEQ_PERF_CNT_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  interp_block_sequencer #(.ROWS_IN(15), .WORDS_OUT(40)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .row_req    (row_req),
    .row_valid  (row_valid),
    .in_load_L  (in_load_L),
    .filt_valid (filt_valid),
    .out_load_L (out_load_L),
    .sel        (sel),
    .dp_reset_L (dp_reset_L),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready)
`ifdef INTERP_SEQ_PERF_CNT_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Block-level reference model
  bit     m_active, m_clear;
  int     m_rows, m_words, m_sel;
  longint m_busy_cyc, m_stall_cyc;

  // Per-sequence statistics gathered from the DUT
  int n_in_loads, n_out_loads, n_dp_low, n_sel_bad, exp_sel_seq;
  int bv_first, first_out, cyc_idx;

  typedef struct {
    bit         s, rv, fv, br;
    logic [13:0] exp;   // {busy,row_req,in_load_L,out_load_L,blk_valid,dp_reset_L,sel}
  } vec_t;
  vec_t tbl [6];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [13:0] dut_vec();
    return {busy, row_req, in_load_L, out_load_L, blk_valid, dp_reset_L, sel};
  endfunction

  function automatic logic [13:0] model_vec();
    bit fill, emit, hold;
    fill = m_active && !m_clear && (m_rows < 15);
    emit = m_active && (m_rows == 15) && (m_words < 40);
    hold = m_active && (m_words == 40);
    return {m_active, fill, !(fill && row_valid), !(emit && filt_valid), hold,
            !(m_clear || reset), 8'(m_sel)};
  endfunction

  function automatic void model_reset();
    m_active = 0; m_clear = 0; m_rows = 0; m_words = 0; m_sel = 0;
    m_busy_cyc = 0; m_stall_cyc = 0;
  endfunction

  function automatic void model_step();
    bit fill, emit, hold;
    fill = m_active && !m_clear && (m_rows < 15);
    emit = m_active && (m_rows == 15) && (m_words < 40);
    hold = m_active && (m_words == 40);
    if (m_active && m_busy_cyc < 64'hFFFF_FFFF) m_busy_cyc++;
    if (((fill && !row_valid) || (emit && !filt_valid)) && m_stall_cyc < 64'hFFFF_FFFF)
      m_stall_cyc++;
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_clear = 1; m_rows = 0; m_words = 0; m_sel = 0;
      end
    end else if (m_clear) begin
      m_clear = 0;
    end else if (fill) begin
      if (row_valid) m_rows++;
    end else if (emit) begin
      if (filt_valid) begin
        m_words++;
        m_sel = (m_words > 39) ? 39 : m_words;
      end
    end else if (hold && blk_ready) begin
      m_active = 0;
    end
  endfunction

  task automatic clr_stats();
    n_in_loads = 0; n_out_loads = 0; n_dp_low = 0; n_sel_bad = 0;
    exp_sel_seq = 0; bv_first = -1; first_out = -1; cyc_idx = 0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge.
  task automatic cyc(input bit s, input bit rv, input bit fv, input bit br);
    start = s; row_valid = rv; filt_valid = fv; blk_ready = br;
    @(negedge clock);
    check("outputs", 32'(dut_vec()), 32'(model_vec()));
`ifdef INTERP_SEQ_PERF_CNT_EN
    check("perf_busy", perf_busy_cyc, 32'(m_busy_cyc));
    check("perf_stall", perf_stall_cyc, 32'(m_stall_cyc));
`endif
    if (in_load_L === 1'b0) n_in_loads++;
    if (out_load_L === 1'b0) begin
      if (sel !== 8'(exp_sel_seq)) n_sel_bad++;
      exp_sel_seq++;
      n_out_loads++;
      if (first_out < 0) first_out = cyc_idx;
    end
    if (dp_reset_L === 1'b0) n_dp_low++;
    if (blk_valid === 1'b1 && bv_first < 0) bv_first = cyc_idx;
    cyc_idx++;
    @(posedge clock);
    model_step();
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; fv lets filt_valid stay asserted.
  task automatic do_reset(input bit fv);
    start = 0; row_valid = 0; filt_valid = fv; blk_ready = 0;
    reset = 1'b1;
    #1;
    check("reset_outs", 32'(dut_vec()), 32'(14'b00_1_1_0_0_00000000));
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("dp_release", 32'(dp_reset_L), 32'd1);
  endtask

  task automatic full_block(input string tag);
    clr_stats();
    cyc(1, 1, 1, 0);
    for (int i = 1; i <= 60; i++) cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 1);
    check({tag, "_in_loads"}, n_in_loads, 15);
    check({tag, "_out_loads"}, n_out_loads, 40);
    check({tag, "_sel_seq"}, n_sel_bad, 0);
    check({tag, "_dp_low"}, n_dp_low, 1);
    check({tag, "_bv_cycle"}, bv_first, 57);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    // Vector table: {start,row_valid,filt_valid,blk_ready} and expected outputs
    tbl[0] = '{s:1'b0, rv:1'b1, fv:1'b1, br:1'b1, exp:14'b00_1_1_0_1_00000000}; // IDLE ignores strobes
    tbl[1] = '{s:1'b1, rv:1'b0, fv:1'b0, br:1'b0, exp:14'b00_1_1_0_1_00000000}; // start sampled
    tbl[2] = '{s:1'b0, rv:1'b1, fv:1'b1, br:1'b0, exp:14'b10_1_1_0_0_00000000}; // CLEAR
    tbl[3] = '{s:1'b0, rv:1'b1, fv:1'b1, br:1'b0, exp:14'b11_0_1_0_1_00000000}; // FILL row, no out load
    tbl[4] = '{s:1'b1, rv:1'b0, fv:1'b1, br:1'b0, exp:14'b11_1_1_0_1_00000000}; // FILL stall, start ignored
    tbl[5] = '{s:1'b0, rv:1'b1, fv:1'b0, br:1'b0, exp:14'b11_0_1_0_1_00000000}; // FILL row

    start = 0; row_valid = 0; filt_valid = 0; blk_ready = 0;
    reset = 1'b1;
    #3;
    check("por_outs", 32'(dut_vec()), 32'(14'b00_1_1_0_0_00000000));
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("por_dp_release", 32'(dp_reset_L), 32'd1);

    for (int i = 0; i < 6; i++) begin
      start = tbl[i].s; row_valid = tbl[i].rv; filt_valid = tbl[i].fv; blk_ready = tbl[i].br;
      @(negedge clock);
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
      @(posedge clock);
      model_step();
      #1;
    end
    do_reset(0);

    // Back-to-back block with all valids high
    full_block("blockA");

    // row_valid low on even cycles: 15 stalls delay EMIT by 15 cycles
    do_reset(0);
    clr_stats();
    cyc(1, 0, 1, 0);
    for (int c = 1; c <= 80; c++) cyc(0, (c % 2) == 1, 1, 1);
    check("toggle_in_loads", n_in_loads, 15);
    check("toggle_emit_cycle", first_out, 32);
    check("toggle_out_loads", n_out_loads, 40);
`ifdef INTERP_SEQ_PERF_CNT_EN
    check("toggle_perf_stall", perf_stall_cyc, 15);
`endif

    // start during FILL/EMIT, then a long HOLD with start asserted
    clr_stats();
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 200 && m_words < 40; i++) cyc(1, 1, 1, 0);
    check("hold_reached", 32'(m_words), 40);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    check("hold_bv", 32'(blk_valid), 1);
    check("hold_sel", 32'(sel), 39);
    check("busystart_in_loads", n_in_loads, 15);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("hold_exit_idle", 32'(busy), 0);
    cyc(0, 0, 0, 0);

    // Reset at word 20 of EMIT, then a full block from scratch
    clr_stats();
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 100 && m_words < 20; i++) cyc(0, 1, 1, 0);
    check("pre_reset_sel", 32'(sel), 20);
    filt_valid = 1'b1;
    #1;
    check("pre_reset_load", 32'(out_load_L), 0);
    do_reset(1);
    full_block("blockD");

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
